// File: rtl/div_last2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_last2_pkg
// Description : Shared FSM encoding and iteration-count helper for div_last2.
// Revision    : 1.0 - initial release
// ============================================================================
package div_last2_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One quotient bit per cycle over a 2*w-bit dividend.
    function automatic int iter_count(input int width);
        return 2 * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_last2_if.sv
`default_nettype none
// ============================================================================
// Module      : div_last2_if
// Description : Sample/result bundle between div_last2 and its environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface div_last2_if #(
    parameter int w = 4
);
    logic [2*w-1:0] in;
    logic           in_valid;
    logic           ld;
    logic           ready;
    logic [w-1:0]   out;
    logic [w-1:0]   rem;
    logic           ovf;
    logic           dz;
    logic           out_valid;

    modport slave (
        input  in, in_valid, ld,
        output ready, out, rem, ovf, dz, out_valid
    );

    modport master (
        output in, in_valid, ld,
        input  ready, out, rem, ovf, dz, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/div_last2_seq_div.sv
`default_nettype none
// ============================================================================
// Module      : seq_div
// Description : Unsigned restoring divider, N-bit dividend by D-bit divisor,
//               one quotient bit per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_div #(
    parameter int N = 8,
    parameter int D = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] i_dividend,
    input  logic [D-1:0] i_divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] o_quotient,
    output logic [D-1:0] o_remainder
);
    localparam int c_cw = $clog2(N + 1);

    logic [N-1:0]    r_quo;
    logic [D-1:0]    r_rem;
    logic [D-1:0]    r_div;
    logic [c_cw-1:0] r_cnt;
    logic            r_busy;
    logic            r_done;

    logic [D:0]      w_trial;
    logic [D-1:0]    w_diff;
    logic            w_fit;

    // Partial remainder stays below the divisor, so the difference fits in D bits.
    assign w_trial = {r_rem, r_quo[N-1]};
    assign w_fit   = w_trial >= {1'b0, r_div};
    assign w_diff  = w_trial[D-1:0] - r_div;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_quo  <= '0;
            r_rem  <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_quo  <= i_dividend;
                r_rem  <= '0;
                r_div  <= i_divisor;
                r_cnt  <= c_cw'(N);
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_quo <= {r_quo[N-2:0], w_fit};
                r_rem <= w_fit ? w_diff : w_trial[D-1:0];
                r_cnt <= r_cnt - 1'b1;
                if (r_cnt == c_cw'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;

endmodule
`default_nettype wire

// File: rtl/div_last2.sv
`default_nettype none
// ============================================================================
// Module      : div_last2
// Description : Divides each accepted product sample by the last recovered
//               operand, with an ignore-value filter and result registers.
// Revision    : 1.0 - initial release
// ============================================================================
module div_last2
    import div_last2_pkg::*;
#(
    parameter int             w   = 4,
    parameter logic [2*w-1:0] ign = '0
) (
    input  logic       clk,
    input  logic       rst,
    div_last2_if.slave bus
);
    localparam int c_iters = iter_count(w);

    state_t         r_state;
    logic           r_ready;
    logic [w-1:0]   r_last;
    logic [2*w-1:0] r_ignore;
    logic [w-1:0]   r_out;
    logic [w-1:0]   r_rem;
    logic           r_ovf;
    logic           r_dz;
    logic           r_out_valid;

    logic           w_accept;
    logic           w_start;
    logic           w_busy;
    logic           w_done;
    logic [2*w-1:0] w_quo;
    logic [w-1:0]   w_rem;
    logic           w_ovf;

    assign w_accept = (r_state == IDLE) && bus.in_valid && !bus.ld && (bus.in != r_ignore);
    // A zero divisor never starts the divider; RUN sees it idle and reports dz.
    assign w_start  = w_accept && (r_last != '0);
    assign w_ovf    = |w_quo[2*w-1:w];

    seq_div #(
        .N (c_iters),
        .D (w)
    ) u_seq_div (
        .clk         (clk),
        .rst         (rst),
        .start       (w_start),
        .i_dividend  (bus.in),
        .i_divisor   (r_last),
        .busy        (w_busy),
        .done        (w_done),
        .o_quotient  (w_quo),
        .o_remainder (w_rem)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ready     <= 1'b1;
            r_last      <= w'(1);
            r_ignore    <= ign;
            r_out       <= '0;
            r_rem       <= '0;
            r_ovf       <= 1'b0;
            r_dz        <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (bus.ld) begin
                r_ignore <= bus.in;
            end
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= RUN;
                        r_ready <= 1'b0;
                    end
                end
                RUN: begin
                    if (w_done) begin
                        r_state     <= DONE;
                        r_out       <= w_quo[w-1:0];
                        r_rem       <= w_rem;
                        r_ovf       <= w_ovf;
                        r_dz        <= 1'b0;
                        r_out_valid <= 1'b1;
                        if (!w_ovf) begin
                            r_last <= w_quo[w-1:0];
                        end
                    end else if (!w_busy) begin
                        r_state     <= DONE;
                        r_out       <= '1;
                        r_rem       <= '0;
                        r_ovf       <= 1'b0;
                        r_dz        <= 1'b1;
                        r_out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready     = r_ready;
    assign bus.out       = r_out;
    assign bus.rem       = r_rem;
    assign bus.ovf       = r_ovf;
    assign bus.dz        = r_dz;
    assign bus.out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_div_last2.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_last2
// Description : Directed and random checks of div_last2 (w=4 and w=6) against
//               an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_last2;

    logic clk;
    logic rst;

    div_last2_if #(.w(4)) bus4 ();
    div_last2_if #(.w(6)) bus6 ();

    div_last2 #(.w(4), .ign(8'd0))  u_dut4 (.clk(clk), .rst(rst), .bus(bus4));
    div_last2 #(.w(6), .ign(12'd0)) u_dut6 (.clk(clk), .rst(rst), .bus(bus6));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state per instance (0: w=4, 1: w=6)
    int m_last [2];
    int m_ign  [2];
    int m_out  [2];
    int m_rem  [2];
    int m_ovf  [2];
    int m_dz   [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input int s, input int val, input bit v, input bit l);
        if (s == 0) begin
            bus4.in = 8'(val); bus4.in_valid = v; bus4.ld = l;
        end else begin
            bus6.in = 12'(val); bus6.in_valid = v; bus6.ld = l;
        end
    endtask

    task automatic sample(input int s, output logic [31:0] o, output logic [31:0] rm,
                          output logic [31:0] ov, output logic [31:0] dz,
                          output logic [31:0] vld, output logic [31:0] rdy);
        if (s == 0) begin
            o = 32'(bus4.out); rm = 32'(bus4.rem); ov = 32'(bus4.ovf);
            dz = 32'(bus4.dz); vld = 32'(bus4.out_valid); rdy = 32'(bus4.ready);
        end else begin
            o = 32'(bus6.out); rm = 32'(bus6.rem); ov = 32'(bus6.ovf);
            dz = 32'(bus6.dz); vld = 32'(bus6.out_valid); rdy = 32'(bus6.ready);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_last[s] = 1; m_ign[s] = 0;
            m_out[s] = 0; m_rem[s] = 0; m_ovf[s] = 0; m_dz[s] = 0;
        end
    endtask

    task automatic check_idle(input int s, input string tag);
        logic [31:0] o, rm, ov, dz, vld, rdy;
        sample(s, o, rm, ov, dz, vld, rdy);
        chk({tag, "_ready"}, rdy, 1);
        chk({tag, "_valid"}, vld, 0);
        chk({tag, "_out"}, o, 32'(m_out[s]));
        chk({tag, "_rem"}, rm, 32'(m_rem[s]));
        chk({tag, "_ovf"}, ov, 32'(m_ovf[s]));
        chk({tag, "_dz"}, dz, 32'(m_dz[s]));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0);
        drive(1, 0, 0, 0);
        step();
        rst = 1'b0;
        model_reset();
    endtask

    // ld together with in_valid: the value becomes the new ignore, no accept.
    task automatic ld_ign(input int s, input int val);
        drive(s, val, 1, 1);
        step();
        drive(s, 0, 0, 0);
        m_ign[s] = val;
        check_idle(s, "ld");
    endtask

    // Present one sample; optionally pulse ld with ld_val at wait cycle ld_at.
    task automatic send(input int s, input int val, input int ld_at, input int ld_val);
        int          w, mask, q, lat, e;
        int          e_out, e_rem, e_ovf, e_dz;
        logic [31:0] o, rm, ov, dz, vld, rdy;
        w    = (s == 0) ? 4 : 6;
        mask = (1 << w) - 1;
        drive(s, val, 1, 0);
        step();
        drive(s, 0, 0, 0);
        if (val == m_ign[s]) begin
            check_idle(s, "drop");
            return;
        end
        if (m_last[s] == 0) begin
            e_out = mask; e_rem = 0; e_ovf = 0; e_dz = 1; lat = 1;
        end else begin
            q     = val / m_last[s];
            e_out = q & mask;
            e_rem = val % m_last[s];
            e_ovf = (q > mask) ? 1 : 0;
            e_dz  = 0;
            lat   = 2 * w + 1;
        end
        sample(s, o, rm, ov, dz, vld, rdy);
        chk("busy_ready", rdy, 0);
        e = 0;
        while (vld == 0 && e < 40) begin
            if (e == ld_at) begin
                drive(s, ld_val, 0, 1);
                m_ign[s] = ld_val;
            end else begin
                drive(s, int'($urandom), 1, 0);
            end
            step();
            drive(s, 0, 0, 0);
            e++;
            sample(s, o, rm, ov, dz, vld, rdy);
        end
        chk("latency", 32'(e), 32'(lat));
        chk("res_out", o, 32'(e_out));
        chk("res_rem", rm, 32'(e_rem));
        chk("res_ovf", ov, 32'(e_ovf));
        chk("res_dz", dz, 32'(e_dz));
        chk("done_ready", rdy, 0);
        m_out[s] = e_out; m_rem[s] = e_rem; m_ovf[s] = e_ovf; m_dz[s] = e_dz;
        if (e_ovf == 0 && e_dz == 0) m_last[s] = e_out;
        step();
        check_idle(s, "after");
    endtask

    initial begin
        int          r, seen;
        logic [31:0] o, rm, ov, dz, vld, rdy;
        rst = 1'b1;
        drive(0, 0, 0, 0);
        drive(1, 0, 0, 0);
        step();
        step();
        rst = 1'b0;
        model_reset();
        check_idle(0, "reset4");
        check_idle(1, "reset6");

        // Basic division chain
        send(0, 10, -1, 0);
        send(0, 50, -1, 0);
        send(0, 15, -1, 0);

        // Ignore filter
        send(0, 0, -1, 0);
        ld_ign(0, 7);
        send(0, 7, -1, 0);
        send(0, 0, -1, 0);

        // Divide by zero, sticky until reset
        send(0, 25, -1, 0);
        send(0, 9, 0, 3);
        send(0, 3, -1, 0);

        // Overflow and remainder
        do_reset();
        send(0, 200, -1, 0);
        send(0, 3, -1, 0);
        send(0, 10, -1, 0);
        send(0, 100, 3, 9);
        send(0, 9, -1, 0);

        // Reset four cycles after accept
        drive(0, 77, 1, 0);
        step();
        drive(0, 0, 0, 0);
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        check_idle(0, "abort");
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            sample(0, o, rm, ov, dz, vld, rdy);
            if (vld != 0) seen++;
        end
        chk("abort_pulse", 32'(seen), 0);
        send(0, 13, -1, 0);

        // Wider instance
        do_reset();
        send(1, 63, -1, 0);
        send(1, 3969, -1, 0);

        // Random traffic
        for (int i = 0; i < 30; i++) begin
            if (m_last[0] == 0) do_reset();
            r = int'($urandom_range(0, 9));
            if (r == 0)      ld_ign(0, int'($urandom_range(0, 255)));
            else if (r == 1) send(0, m_ign[0], -1, 0);
            else if (r == 2) send(0, int'($urandom_range(0, 255)),
                                  int'($urandom_range(0, 8)), int'($urandom_range(0, 255)));
            else             send(0, int'($urandom_range(0, 255)), -1, 0);
        end
        for (int i = 0; i < 6; i++) begin
            if (m_last[1] == 0) do_reset();
            send(1, int'($urandom_range(0, 4095)), -1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
